// File: rtl/prbs16_checker_if.sv
// Stream and status signals between a PRBS16 bit source and prbs16_checker.
interface prbs16_if #(
   parameter int unsigned ERR_W = 16
);
   logic             en;
   logic             bit_valid;
   logic             bit_in;
   logic             clear_cnt;
   logic             locked;
   logic             err_pulse;
   logic             sync_loss;
   logic [ERR_W-1:0] err_count;

   modport master (
      output en, bit_valid, bit_in, clear_cnt,
      input  locked, err_pulse, sync_loss, err_count
   );

   modport slave (
      input  en, bit_valid, bit_in, clear_cnt,
      output locked, err_pulse, sync_loss, err_count
   );
endinterface

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream: fills, verifies,
// then free-runs a local LFSR and counts bit errors with windowed loss-of-sync.
module prbs16_checker #(
   parameter int unsigned LOCK_COUNT  = 32,
   parameter int unsigned WIN_LEN     = 64,
   parameter int unsigned LOSS_THRESH = 8,
   parameter int unsigned ERR_W       = 16
) (
   input  logic     CLK,
   input  logic     rst,
   prbs16_if.slave  bus
);
   localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WW = $clog2(WIN_LEN + 1);
   localparam int unsigned BW = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [15:0]      sr_q, sr_d;
   logic [3:0]       fill_q, fill_d;
   logic [MW-1:0]    match_q, match_d;
   logic [WW-1:0]    win_q, win_d;
   logic [BW-1:0]    bad_q, bad_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_pulse_q, err_pulse_d;
   logic             sync_loss_q, sync_loss_d;
   logic             pred;
   logic             miss;

   assign pred = ~(sr_q[15] ^ sr_q[14] ^ sr_q[12] ^ sr_q[3]);
   assign miss = (bus.bit_in != pred);

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_d       = win_q;
      bad_d       = bad_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      sync_loss_d = 1'b0;

      if (!bus.en) begin
         state_d = SEARCH;
         sr_d    = '0;
         fill_d  = '0;
         match_d = '0;
         win_d   = '0;
         bad_d   = '0;
      end else if (bus.bit_valid) begin
         case (state_q)
            SEARCH: begin
               sr_d   = {sr_q[14:0], bus.bit_in};
               fill_d = fill_q + 4'd1;
               if (fill_q == 4'd15) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end
            end
            VERIFY: begin
               sr_d = {sr_q[14:0], bus.bit_in};
               // All-ones is the XNOR lockup state; a stuck-high line must never qualify.
               if (!miss && (sr_q != '1)) begin
                  match_d = match_q + 1'b1;
                  if (match_d == MW'(LOCK_COUNT)) begin
                     state_d = LOCKED;
                     match_d = '0;
                     win_d   = '0;
                     bad_d   = '0;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               sr_d = {sr_q[14:0], pred};
               // The wrap bit opens the new window, so its error lands in the fresh count.
               if (win_q == WW'(WIN_LEN - 1)) begin
                  win_d = '0;
                  bad_d = '0;
               end else begin
                  win_d = win_q + 1'b1;
               end
               if (miss) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  bad_d = bad_d + 1'b1;
                  if (bad_d == BW'(LOSS_THRESH)) begin
                     state_d     = SEARCH;
                     fill_d      = '0;
                     sync_loss_d = 1'b1;
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      if (bus.clear_cnt) err_cnt_d = '0;
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_q       <= '0;
         bad_q       <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         sync_loss_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_q       <= win_d;
         bad_q       <= bad_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         sync_loss_q <= sync_loss_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.err_pulse = err_pulse_q;
   assign bus.sync_loss = sync_loss_q;
   assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: reference PRBS16 source, lock, error,
// window/loss-of-sync, stuck-high, saturation, clear, enable and reset cases.
module tb_prbs16_checker;
   logic CLK = 1'b0;
   logic rst = 1'b0;

   prbs16_if #(.ERR_W(4)) bus ();

   prbs16_checker #(
      .LOCK_COUNT  (32),
      .WIN_LEN     (64),
      .LOSS_THRESH (8),
      .ERR_W       (4)
   ) dut (
      .CLK (CLK),
      .rst (rst),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned pulse_cnt = 0;
   int unsigned loss_cnt = 0;
   int unsigned lj = 0;
   logic        locked_seen = 1'b0;
   logic [15:0] gen = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge CLK);
      #1;
      bus.bit_valid = 1'b0;
      bus.clear_cnt = 1'b0;
      pulse_cnt += int'(bus.err_pulse);
      loss_cnt  += int'(bus.sync_loss);
      locked_seen |= bus.locked;
   endtask

   task automatic send_raw(input logic b, input logic clr);
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      bus.clear_cnt = clr;
      after_edge();
      lj++;
   endtask

   task automatic send_c(input logic inv, input logic clr);
      logic b;
      b   = ~(gen[15] ^ gen[14] ^ gen[12] ^ gen[3]);
      gen = {gen[14:0], b};
      send_raw(b ^ inv, clr);
   endtask

   task automatic send(input logic inv);
      send_c(inv, 1'b0);
   endtask

   task automatic idle(input logic clr);
      bus.bit_valid = 1'b0;
      bus.clear_cnt = clr;
      after_edge();
   endtask

   task automatic align();
      while ((lj % 64) != 0) send(1'b0);
   endtask

   task automatic do_reset();
      bus.en = 1'b1;
      bus.bit_valid = 1'b0;
      bus.bit_in = 1'b0;
      bus.clear_cnt = 1'b0;
      rst = 1'b0;
      @(posedge CLK);
      #1;
      rst = 1'b1;
      gen = '0;
      pulse_cnt = 0;
      loss_cnt = 0;
      locked_seen = 1'b0;
   endtask

   task automatic relock(input string tag);
      for (int i = 0; i < 47; i++) send(1'b0);
      check({tag, "_pre"}, bus.locked, 0);
      send(1'b0);
      check(tag, bus.locked, 1);
      lj = 0;
   endtask

   initial begin
      int unsigned base;

      // Reset state and clean lock with valid gaps
      do_reset();
      check("rst_locked", bus.locked, 0);
      check("rst_pulse", bus.err_pulse, 0);
      check("rst_loss", bus.sync_loss, 0);
      check("rst_count", bus.err_count, 0);
      for (int i = 1; i <= 47; i++) begin
         send(1'b0);
         if ((i % 7) == 0) idle(1'b0);
      end
      check("lock_47", bus.locked, 0);
      send(1'b0);
      check("lock_48", bus.locked, 1);
      check("lock_count", bus.err_count, 0);
      check("lock_pulses", pulse_cnt, 0);
      lj = 0;

      // Single error
      for (int i = 0; i < 10; i++) send(1'b0);
      send(1'b1);
      check("single_pulse", bus.err_pulse, 1);
      check("single_count", bus.err_count, 1);
      check("single_locked", bus.locked, 1);
      for (int i = 0; i < 100; i++) send(1'b0);
      check("single_pulses", pulse_cnt, 1);
      check("single_locked2", bus.locked, 1);
      idle(1'b1);
      check("clear_idle", bus.err_count, 0);

      // Eight errors in one window
      align();
      for (int k = 0; k < 8; k++) begin
         send(1'b1);
         if (k == 6) begin
            check("loss7_locked", bus.locked, 1);
            check("loss7_cnt", loss_cnt, 0);
         end
         if (k < 7) send(1'b0);
      end
      check("loss_pulse", bus.sync_loss, 1);
      check("loss_locked", bus.locked, 0);
      check("loss_errpulse", bus.err_pulse, 1);
      check("loss_count", bus.err_count, 8);
      relock("relock1");
      check("relock1_noloss", loss_cnt, 1);

      // Seven errors in each of two consecutive windows
      idle(1'b1);
      base = loss_cnt;
      align();
      for (int k = 0; k < 7; k++) begin send(1'b1); send(1'b0); end
      align();
      for (int k = 0; k < 7; k++) begin send(1'b1); send(1'b0); end
      check("twowin_locked", bus.locked, 1);
      check("twowin_count", bus.err_count, 14);
      check("twowin_loss", loss_cnt, base);

      // Error on the wrap bit belongs to the new window
      idle(1'b1);
      align();
      for (int k = 0; k < 7; k++) begin send(1'b1); send(1'b0); end
      while ((lj % 64) != 63) send(1'b0);
      send(1'b1);
      check("wrap_locked", bus.locked, 1);
      check("wrap_count", bus.err_count, 8);
      for (int k = 0; k < 6; k++) begin send(1'b1); send(1'b0); end
      check("wrap_locked7", bus.locked, 1);
      send(1'b1);
      check("wrap_loss", bus.sync_loss, 1);
      check("wrap_unlocked", bus.locked, 0);
      relock("relock2");

      // Stuck-at-1 line never locks
      do_reset();
      for (int i = 0; i < 500; i++) send_raw(1'b1, 1'b0);
      check("stuck_locked", locked_seen, 0);
      check("stuck_count", bus.err_count, 0);
      check("stuck_pulses", pulse_cnt, 0);

      // Saturation, clear vs increment, enable, async reset
      do_reset();
      relock("lock6");
      for (int w = 0; w < 10; w++) begin
         align();
         send(1'b1);
         send(1'b0);
         send(1'b1);
         if (w == 6) check("sat_14", bus.err_count, 14);
      end
      check("sat_count", bus.err_count, 15);
      check("sat_pulses", pulse_cnt, 20);
      check("sat_locked", bus.locked, 1);
      send_c(1'b1, 1'b1);
      check("clr_err_count", bus.err_count, 0);
      check("clr_err_pulse", bus.err_pulse, 1);
      check("clr_locked", bus.locked, 1);
      send(1'b1);
      check("post_clr_count", bus.err_count, 1);
      bus.en = 1'b0;
      send(1'b0);
      check("en0_locked", bus.locked, 0);
      check("en0_loss", bus.sync_loss, 0);
      check("en0_count", bus.err_count, 1);
      bus.en = 1'b1;
      relock("relock_en");
      send(1'b1);
      check("pre_rst_pulse", bus.err_pulse, 1);
      check("pre_rst_count", bus.err_count, 2);
      rst = 1'b0;
      #1;
      check("async_locked", bus.locked, 0);
      check("async_pulse", bus.err_pulse, 0);
      check("async_loss", bus.sync_loss, 0);
      check("async_count", bus.err_count, 0);
      @(posedge CLK);
      #1;
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
